regfile_mp: RTL and testbench

Parametrised multi-port register file for the pipelined CPU datapath, succeeding the fixed 2-read/1-write file. It provides NRD combinational read ports, NWR synchronous write ports with fixed priority, and same-cycle write-to-read bypass. It also carries a per-register busy scoreboard that decode uses to detect RAW hazards against in-flight producers. It sits between decode (read and issue) and writeback (write).

---
 rtl/regfile_mp_pkg.sv | 17 +
 rtl/regfile_mp_wsel.sv | 30 +++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and port-count limits for the multi-port register file.
package regfile_mp_pkg;

    localparam int unsigned DefDw  = 16;
    localparam int unsigned DefAw  = 4;
    localparam int unsigned DefNreg = 2 ** DefAw;
    localparam int unsigned MinRd  = 1;
    localparam int unsigned MaxRd  = 4;
    localparam int unsigned MinWr  = 1;
    localparam int unsigned MaxWr  = 3;

    // Low bit of lane k in a vector of packed w-bit lanes.
    function automatic int unsigned lane_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_mp_wsel.sv
// Fixed-priority write-port select: reports whether any enabled write port targets addr
// and, if so, the data of the highest-index matching port.
module regfile_mp_wsel
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DW  = DefDw,
    parameter int unsigned AW  = DefAw,
    parameter int unsigned NWR = 2
) (
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    input  logic [AW-1:0]     addr,
    output logic              hit,
    output logic [DW-1:0]     data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        // Ascending scan so the highest matching index is the last to assign.
        for (int unsigned k = 0; k < NWR; k++) begin
            if (wen[k] && (waddr[lane_lo(k, AW) +: AW] == addr)) begin
                hit  = 1'b1;
                data = wdata[lane_lo(k, DW) +: DW];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with prioritised writes, write-to-read bypass and a
// per-register busy scoreboard for RAW hazard detection at decode.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DW      = DefDw,
    parameter int unsigned AW      = DefAw,
    parameter int unsigned NRD     = 2,
    parameter int unsigned NWR     = 2,
    parameter bit          ZERO_R0 = 1'b1,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [NWR*DW-1:0] wdata,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr
);

    localparam int unsigned NREG = 2 ** AW;

    logic [DW-1:0]   mem_q [NREG];
    logic [DW-1:0]   mem_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] w_hit;
    logic [DW-1:0]   w_data [NREG];

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        regfile_mp_wsel #(
            .DW  (DW),
            .AW  (AW),
            .NWR (NWR)
        ) u_wsel (
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .addr  (AW'(r)),
            .hit   (w_hit[r]),
            .data  (w_data[r])
        );
    end

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            mem_d[r]  = w_hit[r] ? w_data[r] : mem_q[r];
            // A new issue outranks a same-edge write: the newer producer is still in flight.
            busy_d[r] = (iss_valid && (iss_addr == AW'(r))) ? 1'b1 :
                        w_hit[r] ? 1'b0 : busy_q[r];
            if (ZERO_R0 && (r == 0)) begin
                mem_d[r]  = '0;
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [AW-1:0] ra;
        logic          is_zero;
        logic          r_hit;
        logic [DW-1:0] r_data;
        logic          fwd;

        assign ra = raddr[lane_lo(j, AW) +: AW];

        regfile_mp_wsel #(
            .DW  (DW),
            .AW  (AW),
            .NWR (NWR)
        ) u_wsel (
            .wen   (wen),
            .waddr (waddr),
            .wdata (wdata),
            .addr  (ra),
            .hit   (r_hit),
            .data  (r_data)
        );

        assign is_zero = ZERO_R0 && (ra == '0);
        assign fwd     = BYPASS && r_hit;

        assign rdata[lane_lo(j, DW) +: DW] = (rst || is_zero) ? '0 :
                                             fwd ? r_data : mem_q[ra];
        assign rbusy[j] = !rst && !is_zero && !fwd && busy_q[ra];
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wen;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic [1:0]  rbusy;
    logic        iss_valid;
    logic [3:0]  iss_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_w(input int k, input logic en, input logic [3:0] a, input logic [15:0] d);
        wen[k]          = en;
        waddr[k*4 +: 4] = a;
        wdata[k*16 +: 16] = d;
    endtask

    task automatic set_r(input int j, input logic [3:0] a);
        raddr[j*4 +: 4] = a;
    endtask

    task automatic clr_w();
        wen       = '0;
        iss_valid = 1'b0;
    endtask

    // Advance one edge; inputs change and outputs settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rd(input int j);
        return rdata[j*16 +: 16];
    endfunction

    initial begin
        rst = 1'b1; wen = '0; waddr = '0; wdata = '0; raddr = '0;
        iss_valid = 1'b0; iss_addr = '0;
        step();
        set_r(0, 4'd1);
        #1;
        check("rst_rdata", {16'h0, rd(0)}, 32'h0);
        rst = 1'b0;

        // Reset then read every register on both ports.
        for (int r = 1; r < 16; r++) begin
            set_r(0, 4'(r));
            set_r(1, 4'(15 - r + 1));
            #1;
            check($sformatf("post_rst_rd0_r%0d", r), {16'h0, rd(0)}, 32'h0);
            check($sformatf("post_rst_rd1_r%0d", r), {16'h0, rd(1)}, 32'h0);
            check($sformatf("post_rst_busy_r%0d", r), {30'h0, rbusy}, 32'h0);
        end

        // Write with same-cycle bypass, then read back from the array.
        set_w(0, 1'b1, 4'd5, 16'h1234);
        set_r(0, 4'd5);
        set_r(1, 4'd6);
        #1;
        check("byp_r5", {16'h0, rd(0)}, 32'h1234);
        check("byp_other_port", {16'h0, rd(1)}, 32'h0);
        step();
        clr_w();
        #1;
        check("arr_r5", {16'h0, rd(0)}, 32'h1234);

        // Write collision: highest port wins, for bypass and storage.
        set_w(0, 1'b1, 4'd3, 16'h0AAA);
        set_w(1, 1'b1, 4'd3, 16'h0BBB);
        set_r(1, 4'd3);
        #1;
        check("coll_byp", {16'h0, rd(1)}, 32'h0BBB);
        step();
        clr_w();
        #1;
        check("coll_arr", {16'h0, rd(1)}, 32'h0BBB);
        check("r5_kept", {16'h0, rd(0)}, 32'h1234);

        // Zero register.
        set_w(0, 1'b1, 4'd0, 16'hFFFF);
        iss_valid = 1'b1; iss_addr = 4'd0;
        set_r(0, 4'd0);
        #1;
        check("r0_rd_same", {16'h0, rd(0)}, 32'h0);
        check("r0_busy_same", {31'h0, rbusy[0]}, 32'h0);
        step();
        clr_w();
        #1;
        check("r0_rd_next", {16'h0, rd(0)}, 32'h0);
        check("r0_busy_next", {31'h0, rbusy[0]}, 32'h0);

        // Scoreboard set, hold, bypass clear.
        iss_valid = 1'b1; iss_addr = 4'd7;
        set_r(1, 4'd7);
        #1;
        check("sb_not_yet", {31'h0, rbusy[1]}, 32'h0);
        step();
        clr_w();
        #1;
        check("sb_n1", {31'h0, rbusy[1]}, 32'h1);
        step();
        check("sb_n2", {31'h0, rbusy[1]}, 32'h1);
        step();
        set_w(0, 1'b1, 4'd7, 16'h0777);
        #1;
        check("sb_clr_byp", {31'h0, rbusy[1]}, 32'h0);
        check("sb_clr_data", {16'h0, rd(1)}, 32'h0777);
        step();
        clr_w();
        #1;
        check("sb_clr_arr", {31'h0, rbusy[1]}, 32'h0);
        check("sb_r7_arr", {16'h0, rd(1)}, 32'h0777);

        // Same-edge issue and write: set wins.
        set_w(0, 1'b1, 4'd7, 16'h0888);
        iss_valid = 1'b1; iss_addr = 4'd7;
        #1;
        check("sb_both_byp", {31'h0, rbusy[1]}, 32'h0);
        step();
        clr_w();
        #1;
        check("sb_both_busy", {31'h0, rbusy[1]}, 32'h1);
        check("sb_both_data", {16'h0, rd(1)}, 32'h0888);

        // Reset mid-operation: r9 busy holding 0x0055.
        set_w(1, 1'b1, 4'd9, 16'h0055);
        step();
        clr_w();
        iss_valid = 1'b1; iss_addr = 4'd9;
        step();
        clr_w();
        set_r(0, 4'd9);
        #1;
        check("r9_pre_data", {16'h0, rd(0)}, 32'h0055);
        check("r9_pre_busy", {31'h0, rbusy[0]}, 32'h1);
        rst = 1'b1;
        set_w(0, 1'b1, 4'd9, 16'h0077);
        iss_valid = 1'b1; iss_addr = 4'd4;
        set_r(1, 4'd7);
        #1;
        check("rst_mid_rd", {16'h0, rd(0)}, 32'h0);
        check("rst_mid_busy", {30'h0, rbusy}, 32'h0);
        step();
        rst = 1'b0;
        clr_w();
        #1;
        check("rst_r9_data", {16'h0, rd(0)}, 32'h0);
        check("rst_r9_busy", {31'h0, rbusy[0]}, 32'h0);
        check("rst_r7_busy", {31'h0, rbusy[1]}, 32'h0);
        set_r(0, 4'd5);
        set_r(1, 4'd4);
        #1;
        check("rst_r5_data", {16'h0, rd(0)}, 32'h0);
        check("rst_r4_busy", {31'h0, rbusy[1]}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
